// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the 2-master / 1-slave AXI4-Lite arbiter.
// Contents: bus widths, AXI response codes and the arbiter FSM state encoding.
package axi_lite_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The state also identifies the bus owner: RD_M0 = IFU, RD_M1/WR_M1 = LSU.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_M0 = 2'd1,
    ST_RD_M1 = 2'd2,
    ST_WR_M1 = 2'd3
  } arb_state_e;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bundle (AR, R, AW, W, B channels) shared by the IFU, LSU and slave ports.
// Modports:
//   master - the side that issues requests (drives ar*/aw*/w*, rready, bready)
//   slave  - the side that answers them   (drives arready, r*, awready, wready, b*)
interface axi_lite_arbiter_if;
  import axi_lite_arbiter_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arsize, arvalid, rready,
    output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready,
    input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_arbiter.sv
// Fixed-priority 2:1 AXI4-Lite arbiter.
//   m0 - IFU port (read only; its write channels are ignored and answered with 0)
//   m1 - LSU port (read + write), highest priority
//   s  - downstream slave port
// Ports:
//   clock  in   rising-edge system clock
//   reset  in   asynchronous active-low reset
//   m0, m1      slave modports facing the two masters
//   s           master modport facing the slave
// One transaction is in flight at a time. Only the FSM state is registered;
// all channel routing is a combinational mux selected by the state.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  axi_lite_arbiter_if.slave  m0,
  axi_lite_arbiter_if.slave  m1,
  axi_lite_arbiter_if.master s
);

  arb_state_e state_q, state_d;

  // The IFU never writes; its write-side inputs are intentionally left unconnected.
  logic unused_m0;
  assign unused_m0 = ^{m0.awaddr, m0.awsize, m0.awvalid,
                       m0.wdata, m0.wstrb, m0.wvalid, m0.bready};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Every completion returns to IDLE, so each grant sees a fresh priority
  // decision (one bubble cycle between back-to-back transactions).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m1.awvalid)      state_d = ST_WR_M1;
        else if (m1.arvalid) state_d = ST_RD_M1;
        else if (m0.arvalid) state_d = ST_RD_M0;
      end
      ST_RD_M0: if (s.rvalid && m0.rready) state_d = ST_IDLE;
      ST_RD_M1: if (s.rvalid && m1.rready) state_d = ST_IDLE;
      ST_WR_M1: if (s.bvalid && m1.bready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Channel routing: everything not owned in the current state is held at 0,
  // which also makes all handshakes idle while reset forces the state to IDLE.
  always_comb begin
    s.araddr   = '0;
    s.arsize   = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awaddr   = '0;
    s.awsize   = '0;
    s.awvalid  = 1'b0;
    s.wdata    = '0;
    s.wstrb    = '0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;

    m0.arready = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = '0;
    m0.bvalid  = 1'b0;

    m1.arready = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = '0;
    m1.bvalid  = 1'b0;

    case (state_q)
      ST_RD_M0: begin
        s.araddr   = m0.araddr;
        s.arsize   = m0.arsize;
        s.arvalid  = m0.arvalid;
        m0.arready = s.arready;
        s.rready   = m0.rready;
        m0.rdata   = s.rdata;
        m0.rresp   = s.rresp;
        m0.rvalid  = s.rvalid;
      end
      ST_RD_M1: begin
        s.araddr   = m1.araddr;
        s.arsize   = m1.arsize;
        s.arvalid  = m1.arvalid;
        m1.arready = s.arready;
        s.rready   = m1.rready;
        m1.rdata   = s.rdata;
        m1.rresp   = s.rresp;
        m1.rvalid  = s.rvalid;
      end
      ST_WR_M1: begin
        // AW and W are independent pass-throughs, so they may complete in
        // either order or together.
        s.awaddr   = m1.awaddr;
        s.awsize   = m1.awsize;
        s.awvalid  = m1.awvalid;
        m1.awready = s.awready;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid;
        m1.wready  = s.wready;
        s.bready   = m1.bready;
        m1.bresp   = s.bresp;
        m1.bvalid  = s.bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Testbench for axi_lite_arbiter: directed scenarios plus a randomized phase.
// Masters push expected responses into per-channel queues when they issue a
// request; a monitor pops and compares whenever a response handshake occurs.
// The slave model answers reads with a fixed address->data map.
module tb_axi_lite_arbiter;
  import axi_lite_arbiter_pkg::*;

  localparam int BUDGET = 200;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  axi_lite_arbiter_if m0_if ();
  axi_lite_arbiter_if m1_if ();
  axi_lite_arbiter_if s_if ();

  axi_lite_arbiter dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;

  rsp_t       exp_m0[$];
  rsp_t       exp_m1r[$];
  logic [1:0] exp_b[$];
  wr_t        exp_wr[$];

  int checks = 0;
  int errors = 0;

  // slave knobs
  int rd_lat    = 0;
  bit rnd_ready = 1'b0;
  bit w_first   = 1'b0;

  // monitor observations
  logic [31:0] last_m0_rdata, last_m1_rdata;
  logic [1:0]  last_m0_rresp, last_m1_rresp;
  int          m1_rfire_cyc = 0;
  int          sar_rise_cyc = 0;
  logic [31:0] sar_rise_addr = '0;
  int          m1_bcount = 0;

  // Slave memory map: read data and response are a pure function of address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'h8000_0413;
  endfunction

  function automatic logic [1:0] resp_fn(input logic [31:0] a);
    return (a[3:2] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d cycles, expected handshake", name, BUDGET);
  endtask

  function automatic logic [31:0] dut_hs();
    return {17'b0,
            m0_if.arready, m0_if.rvalid, m0_if.awready, m0_if.wready, m0_if.bvalid,
            m1_if.arready, m1_if.rvalid, m1_if.awready, m1_if.wready, m1_if.bvalid,
            s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid, s_if.bready};
  endfunction

  // ---------------- master tasks ----------------
  task automatic m0_read(input logic [31:0] a, input bit rnd);
    int n;
    bit done;
    rsp_t e;
    e.data = rd_fn(a);
    e.resp = resp_fn(a);
    exp_m0.push_back(e);
    @(negedge clock);
    m0_if.araddr  = a;
    m0_if.arsize  = 3'd2;
    m0_if.arvalid = 1'b1;
    #1;
    n = 0;
    while (!m0_if.arready && n < BUDGET) begin @(negedge clock); #1; n++; end
    if (n >= BUDGET) timeout("m0_ar");
    @(negedge clock);
    m0_if.arvalid = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < BUDGET) begin
      m0_if.rready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      #1;
      done = m0_if.rvalid && m0_if.rready;
      @(negedge clock);
      n++;
    end
    if (!done) timeout("m0_r");
    m0_if.rready = 1'b0;
  endtask

  task automatic m1_read(input logic [31:0] a, input bit rnd);
    int n;
    bit done;
    rsp_t e;
    e.data = rd_fn(a);
    e.resp = resp_fn(a);
    exp_m1r.push_back(e);
    @(negedge clock);
    m1_if.araddr  = a;
    m1_if.arsize  = 3'd2;
    m1_if.arvalid = 1'b1;
    #1;
    n = 0;
    while (!m1_if.arready && n < BUDGET) begin @(negedge clock); #1; n++; end
    if (n >= BUDGET) timeout("m1_ar");
    @(negedge clock);
    m1_if.arvalid = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < BUDGET) begin
      m1_if.rready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      #1;
      done = m1_if.rvalid && m1_if.rready;
      @(negedge clock);
      n++;
    end
    if (!done) timeout("m1_r");
    m1_if.rready = 1'b0;
  endtask

  task automatic m1_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input bit rnd);
    int n;
    bit aw_done, w_done, aw_f, w_f, done;
    wr_t w;
    w.addr = a;
    w.data = d;
    w.strb = st;
    exp_wr.push_back(w);
    exp_b.push_back(resp_fn(a));
    @(negedge clock);
    m1_if.awaddr  = a;
    m1_if.awsize  = 3'd2;
    m1_if.awvalid = 1'b1;
    m1_if.wdata   = d;
    m1_if.wstrb   = st;
    m1_if.wvalid  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < BUDGET) begin
      #1;
      aw_f = m1_if.awvalid && m1_if.awready;
      w_f  = m1_if.wvalid && m1_if.wready;
      @(negedge clock);
      n++;
      if (aw_f) begin m1_if.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_f)  begin m1_if.wvalid  = 1'b0; w_done  = 1'b1; end
    end
    if (!(aw_done && w_done)) timeout("m1_aw_w");
    m1_if.awvalid = 1'b0;
    m1_if.wvalid  = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < BUDGET) begin
      m1_if.bready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      #1;
      done = m1_if.bvalid && m1_if.bready;
      @(negedge clock);
      n++;
    end
    if (!done) timeout("m1_b");
    m1_if.bready = 1'b0;
  endtask

  // ---------------- slave model ----------------
  initial begin : slave
    bit ar_f, r_f, aw_f, w_f, b_f, rd_pend, have_aw, have_w;
    int rd_cnt;
    logic [31:0] rd_a, wa, wd;
    logic [3:0]  ws;
    wr_t e;
    ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
    rd_pend = 0; have_aw = 0; have_w = 0; rd_cnt = 0;
    rd_a = '0; wa = '0; wd = '0; ws = '0;
    s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.rresp = '0;
    s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
        rd_pend = 0; have_aw = 0; have_w = 0;
        s_if.arready = 0; s_if.rvalid = 0; s_if.awready = 0;
        s_if.wready = 0; s_if.bvalid = 0;
      end else begin
        if (ar_f) begin
          rd_pend = 1;
          rd_cnt  = rnd_ready ? int'($urandom_range(3, 0)) : rd_lat;
        end
        if (r_f) begin rd_pend = 0; s_if.rvalid = 0; end
        if (aw_f) have_aw = 1;
        if (w_f)  have_w  = 1;
        if ((aw_f || w_f) && have_aw && have_w) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL s_write_unexpected: got addr %h, expected no write", wa);
          end else begin
            e = exp_wr.pop_front();
            chk("s_awaddr", wa, e.addr);
            chk("s_wdata", wd, e.data);
            chk("s_wstrb", 32'(ws), 32'(e.strb));
          end
        end
        if (b_f) begin s_if.bvalid = 0; have_aw = 0; have_w = 0; end
        if (rd_pend && !s_if.rvalid) begin
          if (rd_cnt == 0) begin
            s_if.rvalid = 1;
            s_if.rdata  = rd_fn(rd_a);
            s_if.rresp  = resp_fn(rd_a);
          end else rd_cnt--;
        end
        if (have_aw && have_w && !s_if.bvalid) begin
          s_if.bvalid = 1;
          s_if.bresp  = resp_fn(wa);
        end
        s_if.arready = !rd_pend && (!rnd_ready || $urandom_range(1, 0) == 1);
        s_if.wready  = !have_w && (!rnd_ready || $urandom_range(1, 0) == 1);
        s_if.awready = !have_aw && (!w_first || have_w) &&
                       (!rnd_ready || $urandom_range(1, 0) == 1);
        #1;
        ar_f = s_if.arvalid && s_if.arready;
        if (ar_f) rd_a = s_if.araddr;
        r_f  = s_if.rvalid && s_if.rready;
        aw_f = s_if.awvalid && s_if.awready;
        if (aw_f) wa = s_if.awaddr;
        w_f  = s_if.wvalid && s_if.wready;
        if (w_f) begin wd = s_if.wdata; ws = s_if.wstrb; end
        b_f  = s_if.bvalid && s_if.bready;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit prev_sar;
    rsp_t e;
    logic [1:0] eb;
    prev_sar = 0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        if (m0_if.rvalid && m0_if.rready) begin
          last_m0_rdata = m0_if.rdata;
          last_m0_rresp = m0_if.rresp;
          if (exp_m0.size() == 0) begin
            checks++; errors++;
            $display("FAIL m0_r_unexpected: got %h, expected no response", m0_if.rdata);
          end else begin
            e = exp_m0.pop_front();
            chk("m0_rdata", m0_if.rdata, e.data);
            chk("m0_rresp", 32'(m0_if.rresp), 32'(e.resp));
          end
        end
        if (m1_if.rvalid && m1_if.rready) begin
          last_m1_rdata = m1_if.rdata;
          last_m1_rresp = m1_if.rresp;
          m1_rfire_cyc  = cyc;
          if (exp_m1r.size() == 0) begin
            checks++; errors++;
            $display("FAIL m1_r_unexpected: got %h, expected no response", m1_if.rdata);
          end else begin
            e = exp_m1r.pop_front();
            chk("m1_rdata", m1_if.rdata, e.data);
            chk("m1_rresp", 32'(m1_if.rresp), 32'(e.resp));
          end
        end
        if (m1_if.bvalid && m1_if.bready) begin
          m1_bcount++;
          if (exp_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL m1_b_unexpected: got %h, expected no response", m1_if.bresp);
          end else begin
            eb = exp_b.pop_front();
            chk("m1_bresp", 32'(m1_if.bresp), 32'(eb));
          end
        end
        // exclusivity: only one owner may see its channels active at a time
        chk("exclusive", 32'((s_if.arvalid && s_if.awvalid) ||
                             (m0_if.rvalid && (m1_if.rvalid || m1_if.bvalid)) ||
                             (m0_if.arready && (m1_if.arready || m1_if.awready || m1_if.wready)) ||
                             m0_if.awready || m0_if.wready || m0_if.bvalid), 32'd0);
        if (s_if.arvalid && !prev_sar) begin
          sar_rise_cyc  = cyc;
          sar_rise_addr = s_if.araddr;
        end
        prev_sar = s_if.arvalid;
      end else prev_sar = 0;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    bit stall;
    int n, b0, rel_cyc;
    m0_if.araddr = '0; m0_if.arsize = '0; m0_if.arvalid = 0; m0_if.rready = 0;
    m0_if.awaddr = '0; m0_if.awsize = '0; m0_if.awvalid = 0;
    m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wvalid = 0; m0_if.bready = 0;
    m1_if.araddr = '0; m1_if.arsize = '0; m1_if.arvalid = 0; m1_if.rready = 0;
    m1_if.awaddr = '0; m1_if.awsize = '0; m1_if.awvalid = 0;
    m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wvalid = 0; m1_if.bready = 0;

    repeat (3) @(negedge clock);
    #1;
    chk("reset_outputs", dut_hs(), 32'd0);
    #1;
    reset = 1'b1;

    // 1) IFU read, slave answers after a 2-cycle delay
    rd_lat = 2;
    m0_read(32'h8000_0000, 1'b0);
    chk("t1_rdata", last_m0_rdata, 32'h0000_0413);
    chk("t1_rresp", 32'(last_m0_rresp), 32'(RESP_OKAY));
    chk("t1_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // 2) simultaneous requests: LSU first, IFU after R handshake + bubble
    rd_lat = 0;
    fork
      m0_read(32'h8000_0040, 1'b0);
      m1_read(32'h8000_1000, 1'b0);
      begin
        @(negedge clock); #1;
        chk("t2_request_cycle_no_ar", 32'(s_if.arvalid), 32'd0);
        @(negedge clock); #1;
        chk("t2_lsu_first_valid", 32'(s_if.arvalid), 32'd1);
        chk("t2_lsu_first_addr", s_if.araddr, 32'h8000_1000);
        chk("t2_ifu_stalled", 32'(m0_if.arready), 32'd0);
      end
    join
    chk("t2_ifu_addr", sar_rise_addr, 32'h8000_0040);
    chk("t2_bubble", 32'(sar_rise_cyc - m1_rfire_cyc), 32'd2);

    // 3) LSU byte store, slave takes W before AW; IFU held off throughout
    w_first = 1'b1;
    b0 = m1_bcount;
    stall = 1'b0;
    fork
      m1_write(32'h1000_0000, 32'h0000_0041, 4'b0001, 1'b0);
      m0_read(32'h8000_0080, 1'b0);
      begin
        n = 0;
        do begin
          @(negedge clock); #1;
          if (m0_if.arready) stall = 1'b1;
          n++;
        end while (!(m1_if.bvalid && m1_if.bready) && n < BUDGET);
        if (n >= BUDGET) timeout("t3_b_wait");
      end
    join
    w_first = 1'b0;
    chk("t3_m0_arready_during_write", 32'(stall), 32'd0);
    chk("t3_single_b", 32'(m1_bcount - b0), 32'd1);

    // 4) error response forwarded unchanged
    m1_read(32'h4000_000C, 1'b0);
    chk("t4_rresp", 32'(last_m1_rresp), 32'(RESP_SLVERR));
    chk("t4_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // 5) reset during RD_M1 with a pending slave response
    rd_lat = 1;
    @(negedge clock);
    m1_if.araddr  = 32'h4000_0100;
    m1_if.arvalid = 1'b1;
    m1_if.rready  = 1'b0;
    #1;
    n = 0;
    while (!m1_if.arready && n < BUDGET) begin @(negedge clock); #1; n++; end
    if (n >= BUDGET) timeout("t5_ar");
    @(negedge clock);
    m1_if.arvalid = 1'b0;
    #1;
    n = 0;
    while (!s_if.rvalid && n < BUDGET) begin @(negedge clock); #1; n++; end
    if (n >= BUDGET) timeout("t5_rvalid");
    chk("t5_m1_rvalid_before_reset", 32'(m1_if.rvalid), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_outputs_in_reset", dut_hs(), 32'd0);
    repeat (2) @(negedge clock);
    #1;
    chk("t5_outputs_held_in_reset", dut_hs(), 32'd0);
    #1;
    reset = 1'b1;
    rel_cyc = cyc;
    rd_lat = 0;
    m0_read(32'h8000_0200, 1'b0);
    chk("t5_first_grant", 32'(sar_rise_cyc - rel_cyc), 32'd2);
    chk("t5_rdata", last_m0_rdata, rd_fn(32'h8000_0200));

    // randomized traffic from both masters against a random-ready slave
    rnd_ready = 1'b1;
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(3, 0)) @(negedge clock);
          m0_read(32'h8000_0000 | ($urandom_range(255, 0) << 2), 1'b1);
        end
      end
      begin
        repeat (40) begin
          repeat ($urandom_range(3, 0)) @(negedge clock);
          if ($urandom_range(1, 0) == 1)
            m1_write(32'h1000_0000 | ($urandom_range(255, 0) << 2), $urandom,
                     4'($urandom_range(15, 1)), 1'b1);
          else
            m1_read(32'h4000_0000 | ($urandom_range(255, 0) << 2), 1'b1);
        end
      end
    join
    repeat (5) @(negedge clock);
    chk("drain_m0", 32'(exp_m0.size()), 32'd0);
    chk("drain_m1r", 32'(exp_m1r.size()), 32'd0);
    chk("drain_b", 32'(exp_b.size()), 32'd0);
    chk("drain_wr", 32'(exp_wr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
